alu_result_stage: RTL
=====================

// Module: alu_result_stage
// PURPOSE
//  Registered output stage directly downstream of the ALU. Captures Result/Z/C/N/OF plus the
//  writeback tag with a valid/ready handshake and decouples ALU timing from writeback via a
//  2-entry skid buffer. Holds the architectural NZCV flags register and provides a forwarding tap.
// PARAMETERS
//  WIDTH     alu_pkg::WIDTH  datapath width; must match the ALU
//  REG_AW    5               destination register address width
// PORTS
//  clk_i          in   1        clock
//  rst_ni         in   1        reset: one clock; reset is asynchronous and active-low
//  valid_i        in   1        ALU result valid
//  ready_o        out  1        stage can accept (registered, = !skid_full)
//  Result_i       in   WIDTH    ALU result
//  Z_i/C_i/N_i/OF_i in 1 each   ALU flags
//  RdAddr_i       in   REG_AW   destination register
//  WrEn_i         in   1        result is to be written back
//  SetFlags_i     in   1        instruction updates NZCV
//  valid_o        out  1        writeback entry valid
//  ready_i        in   1        writeback consumer accepts
//  Result_o       out  WIDTH    writeback data
//  RdAddr_o       out  REG_AW   writeback address
//  WrEn_o         out  1        writeback enable (0 when RdAddr == 0)
//  Flags_o        out  4        architectural {N,Z,C,V}
//  FwdValid_o     out  1        youngest buffered entry writes a register
//  FwdAddr_o      out  REG_AW   its address
//  FwdData_o      out  WIDTH    its data
// BEHAVIOUR
//  - Push = valid_i & ready_o; pop = valid_o & ready_i. Storage: main reg (drives *_o) + skid reg.
//  - Reset (async assert, sync deassert external): valid_o=0, ready_o=1, Result_o='0, RdAddr_o='0,
//    WrEn_o=0, Flags_o=4'b0000, FwdValid_o=0, skid empty. Mid-operation reset drops all entries.
//  - Latency: accepted entry appears on *_o the next cycle when main is empty or popping.
//  - Main empty or popping: push loads main; skid stays empty.
//  - Main full, not popping, push: entry goes to skid; ready_o falls next cycle.
//  - Pop with skid full: skid moves to main the same edge; ready_o rises next cycle. No push
//    accepted while ready_o=0; no entry is lost or duplicated; order preserved.
//  - Simultaneous push+pop with skid empty: main reloads with new entry, valid_o stays 1.
//  - While valid_o=1 & !ready_i, *_o stay stable (AXI-style hold).
//  - WrEn stored as WrEn_i & (RdAddr_i != 0).
//  - Flags: on push with SetFlags_i=1, Flags_o <= {N_i,Z_i,C_i,OF_i} next cycle (program order,
//    independent of downstream stall). SetFlags_i=0 or no push: Flags_o holds.
//  - Forward tap: skid if full, else main if valid_o; FwdValid_o = selected valid & WrEn; data/addr
//    of the selected entry, '0 when FwdValid_o=0.
//  - Inputs are sampled only on push; valid_i without ready_o has no effect.
// STRUCTURE
//  - alu_pkg: WIDTH, new flags_t packed struct {n,z,c,v}, wb_entry_t {result, rd, we}.
//  - One sub-module, skid_buffer #(type T=wb_entry_t), reusable for other stages; flags register
//    and forward mux are in this top module.
// TESTING
//  1 Reset mid-stream with valid_o=1 -> next cycle valid_o=0, ready_o=1, Flags_o=0.
//  2 push {Result=32'h0000_0005, Rd=3, We=1}, ready_i=1 -> next cycle valid_o=1, Result_o=5,
//    RdAddr_o=3, WrEn_o=1, FwdValid_o=1, FwdAddr_o=3.
//  3 ready_i=0, push A=1 then B=2 -> ready_o=0 after B; C=3 held at input is not taken;
//    release ready_i -> outputs A, B, C in order, never duplicated.
//  4 push Rd=0, WrEn_i=1 -> WrEn_o=0, FwdValid_o=0.
//  5 push SetFlags=1 with Z=1, C=1 (SUB 7-7), then SetFlags=0 with N=1 -> Flags_o=4'b0110
//    and holds.
//  6 Back-to-back push+pop every cycle for 100 random entries -> valid_o continuous, ready_o
//    stays 1, scoreboard matches.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: datapath widths, flag register layout
// and the writeback entry carried through the skid buffer.
package alu_pkg;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;

  // Architectural flags, packed so that the vector reads {N,Z,C,V}.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // One writeback entry; 'we' is already cleared for writes to register 0.
  typedef struct packed {
    logic [WIDTH-1:0]  result;
    logic [REG_AW-1:0] rd;
    logic              we;
  } wb_entry_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with a registered ready. The main register drives the
// output; the skid register catches the one entry accepted while the output
// is stalled, so upstream ready never depends combinationally on out_ready.
module skid_buffer
  import alu_pkg::*;
#(
  parameter type T = wb_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data,
  output logic skid_valid,
  output T     skid_data
);

  logic push;
  logic pop;

  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Main/skid occupancy and data: refill main from skid first, otherwise from input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      // NOTE: the data registers are reset too because the zero value is
      // visible on the outputs after reset; storage that is never observed
      // before being written would normally be left unreset.
      out_data   <= '0;
      skid_data  <= '0;
    end else begin
      // NOTE: every sequential update uses <= so all registers see the
      // pre-edge values of each other regardless of statement order.
      if (skid_valid) begin
        // in_ready is low here, so no push can coincide with a skid entry.
        if (pop) begin
          out_data   <= skid_data;
          skid_valid <= 1'b0;
        end
      end else if (push) begin
        if (!out_valid || pop) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          skid_data  <= in_data;
          skid_valid <= 1'b1;
        end
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: buffers result/tag through a skid
// buffer, keeps the architectural NZCV register in program order and exposes
// the youngest buffered register write as a forwarding tap.
module alu_result_stage #(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int REG_AW = alu_pkg::REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  Result_i,
  input  logic              Z_i,
  input  logic              C_i,
  input  logic              N_i,
  input  logic              OF_i,
  input  logic [REG_AW-1:0] RdAddr_i,
  input  logic              WrEn_i,
  input  logic              SetFlags_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  Result_o,
  output logic [REG_AW-1:0] RdAddr_o,
  output logic              WrEn_o,
  output logic [3:0]        Flags_o,
  output logic              FwdValid_o,
  output logic [REG_AW-1:0] FwdAddr_o,
  output logic [WIDTH-1:0]  FwdData_o
);

  alu_pkg::wb_entry_t in_entry;
  alu_pkg::wb_entry_t main_entry;
  alu_pkg::wb_entry_t skid_entry;
  alu_pkg::flags_t    flags_q;
  logic               skid_full;
  logic               push;

  assign push = valid_i && ready_o;

  // Pack the incoming entry; a write to register 0 is never a real write.
  always_comb begin
    in_entry.result = Result_i;
    in_entry.rd     = RdAddr_i;
    in_entry.we     = WrEn_i && (RdAddr_i != '0);
  end

  skid_buffer #(
    .T (alu_pkg::wb_entry_t)
  ) u_skid (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .in_valid   (valid_i),
    .in_ready   (ready_o),
    .in_data    (in_entry),
    .out_valid  (valid_o),
    .out_ready  (ready_i),
    .out_data   (main_entry),
    .skid_valid (skid_full),
    .skid_data  (skid_entry)
  );

  assign Result_o = main_entry.result;
  assign RdAddr_o = main_entry.rd;
  assign WrEn_o   = main_entry.we;
  assign Flags_o  = flags_q;

  // Flags follow accepted instructions in issue order, independent of downstream stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= '0;
    end else if (push && SetFlags_i) begin
      flags_q <= '{n: N_i, z: Z_i, c: C_i, v: OF_i};
    end
  end

  // Forward tap selects the youngest buffered entry: skid when occupied, else main.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    FwdValid_o = 1'b0;
    FwdAddr_o  = '0;
    FwdData_o  = '0;
    if (skid_full) begin
      if (skid_entry.we) begin
        FwdValid_o = 1'b1;
        FwdAddr_o  = skid_entry.rd;
        FwdData_o  = skid_entry.result;
      end
    end else if (valid_o && main_entry.we) begin
      FwdValid_o = 1'b1;
      FwdAddr_o  = main_entry.rd;
      FwdData_o  = main_entry.result;
    end
  end

endmodule
